memory_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execution stage.
- Consumes the registered ALU result, load/store controls, store data and writeback controls.
- Performs data-cache accesses through a valid/ready request and response handshake, aligns and extends load data, and generates store byte enables.
- Registers results for the writeback stage. Asserts a stall back to the execution stage while an access is outstanding.

---
 rtl/memory_access_stage_if.sv | 30 +++
 rtl/memory_access_stage.sv | 177 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// Data-cache port of the memory access stage: request channel plus load-response channel.
interface memory_access_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // A request transfers on a rising CLK edge where DCACHE_REQ_VALID and DCACHE_REQ_READY are
    // both high; once VALID rises it stays high with all request fields stable until that edge,
    // and READY is ignored while VALID is low. DCACHE_RESP_VALID qualifies DCACHE_RESP_DATA for
    // one cycle and carries no ready.
    logic                    DCACHE_REQ_VALID;
    logic                    DCACHE_REQ_READY;
    logic                    DCACHE_REQ_WRITE;
    logic [ADDRESS_WIDTH-1:0] DCACHE_REQ_ADDRESS;
    logic [DATA_WIDTH/8-1:0] DCACHE_REQ_BYTE_EN;
    logic [DATA_WIDTH-1:0]   DCACHE_REQ_WDATA;
    logic                    DCACHE_RESP_VALID;
    logic [DATA_WIDTH-1:0]   DCACHE_RESP_DATA;

    modport master (
        output DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_REQ_ADDRESS,
        output DCACHE_REQ_BYTE_EN, DCACHE_REQ_WDATA,
        input  DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RESP_DATA
    );

    modport slave (
        input  DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_REQ_ADDRESS,
        input  DCACHE_REQ_BYTE_EN, DCACHE_REQ_WDATA,
        output DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RESP_DATA
    );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: issues data-cache requests, aligns/extends loads, encodes
// store byte lanes and registers results for writeback. STATE_OUT exposes the FSM state.
module memory_access_stage #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADD_WIDTH    = 5,
    parameter int D_CACHE_LW_WIDTH = 3,
    parameter int D_CACHE_SW_WIDTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
    input  logic [DATA_WIDTH-1:0]       ALU_OUT_IN,
    input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
    input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
    input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
    input  logic                        WRITE_BACK_MUX_SELECT_IN,
    input  logic                        RD_WRITE_ENABLE_IN,
    output logic                        STALL_EXECUTION_STAGE,
    memory_access_stage_if.master       dcache,
    output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
    output logic [DATA_WIDTH-1:0]       ALU_OUT,
    output logic [DATA_WIDTH-1:0]       MEM_DATA_OUT,
    output logic                        WRITE_BACK_MUX_SELECT_OUT,
    output logic                        RD_WRITE_ENABLE_OUT,
    output logic                        MISALIGNED_OUT,
    output logic [1:0]                  STATE_OUT
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [D_CACHE_LW_WIDTH-1:0] LOAD_LB  = 3'd1;
    localparam logic [D_CACHE_LW_WIDTH-1:0] LOAD_LH  = 3'd2;
    localparam logic [D_CACHE_LW_WIDTH-1:0] LOAD_LW  = 3'd3;
    localparam logic [D_CACHE_LW_WIDTH-1:0] LOAD_LBU = 3'd4;
    localparam logic [D_CACHE_LW_WIDTH-1:0] LOAD_LHU = 3'd5;
    localparam logic [D_CACHE_SW_WIDTH-1:0] STORE_SB = 2'd1;
    localparam logic [D_CACHE_SW_WIDTH-1:0] STORE_SH = 2'd2;
    localparam logic [D_CACHE_SW_WIDTH-1:0] STORE_SW = 2'd3;

    logic [1:0]            state;
    logic [1:0]            lane;
    logic                  is_load;
    logic                  is_store;
    logic                  is_op;
    logic                  misaligned;
    logic [3:0]            store_byte_en;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] hold_data;

    assign lane = ALU_OUT_IN[1:0];

    // A load code takes priority; the store code only counts when no load is present.
    always_comb begin
        is_load    = (DATA_CACHE_LOAD_IN >= LOAD_LB) && (DATA_CACHE_LOAD_IN <= LOAD_LHU);
        is_store   = !is_load && (DATA_CACHE_STORE_IN != '0);
        is_op      = is_load || is_store;
        misaligned = 1'b0;
        if (is_load) begin
            case (DATA_CACHE_LOAD_IN)
                LOAD_LH, LOAD_LHU: misaligned = lane[0];
                LOAD_LW:           misaligned = (lane != 2'b00);
                default:           misaligned = 1'b0;
            endcase
        end else if (is_store) begin
            case (DATA_CACHE_STORE_IN)
                STORE_SH: misaligned = lane[0];
                STORE_SW: misaligned = (lane != 2'b00);
                default:  misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        store_byte_en = 4'b0000;
        store_wdata   = '0;
        if (is_store) begin
            case (DATA_CACHE_STORE_IN)
                STORE_SB: begin
                    store_byte_en = 4'b0001 << lane;
                    store_wdata   = {4{DATA_CACHE_STORE_DATA[7:0]}};
                end
                STORE_SH: begin
                    store_byte_en = 4'b0011 << lane;
                    store_wdata   = {2{DATA_CACHE_STORE_DATA[15:0]}};
                end
                default: begin
                    store_byte_en = 4'b1111;
                    store_wdata   = DATA_CACHE_STORE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        case (lane)
            2'd0:    load_byte = dcache.DCACHE_RESP_DATA[7:0];
            2'd1:    load_byte = dcache.DCACHE_RESP_DATA[15:8];
            2'd2:    load_byte = dcache.DCACHE_RESP_DATA[23:16];
            default: load_byte = dcache.DCACHE_RESP_DATA[31:24];
        endcase
        load_half = lane[1] ? dcache.DCACHE_RESP_DATA[31:16] : dcache.DCACHE_RESP_DATA[15:0];
        case (DATA_CACHE_LOAD_IN)
            LOAD_LB:  load_ext = {{24{load_byte[7]}}, load_byte};
            LOAD_LBU: load_ext = {24'd0, load_byte};
            LOAD_LH:  load_ext = {{16{load_half[15]}}, load_half};
            LOAD_LHU: load_ext = {16'd0, load_half};
            LOAD_LW:  load_ext = dcache.DCACHE_RESP_DATA;
            default:  load_ext = '0;
        endcase
    end

    assign dcache.DCACHE_REQ_VALID   = (state == S_REQ);
    assign dcache.DCACHE_REQ_WRITE   = is_store;
    assign dcache.DCACHE_REQ_ADDRESS = {ALU_OUT_IN[ADDRESS_WIDTH-1:2], 2'b00};
    assign dcache.DCACHE_REQ_BYTE_EN = store_byte_en;
    assign dcache.DCACHE_REQ_WDATA   = store_wdata;

    assign STALL_EXECUTION_STAGE = ((state == S_IDLE) && is_op && !misaligned)
                                 || (state == S_REQ) || (state == S_WAIT);
    assign STATE_OUT = state;

    // The execution stage is stalled in REQ/WAIT, so the inputs still describe the access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state                     <= S_IDLE;
            hold_data                 <= '0;
            RD_ADDRESS_OUT            <= '0;
            ALU_OUT                   <= '0;
            MEM_DATA_OUT              <= '0;
            WRITE_BACK_MUX_SELECT_OUT <= 1'b0;
            RD_WRITE_ENABLE_OUT       <= 1'b0;
            MISALIGNED_OUT            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!is_op || misaligned) begin
                        RD_ADDRESS_OUT            <= RD_ADDRESS_IN;
                        ALU_OUT                   <= ALU_OUT_IN;
                        MEM_DATA_OUT              <= '0;
                        WRITE_BACK_MUX_SELECT_OUT <= WRITE_BACK_MUX_SELECT_IN;
                        RD_WRITE_ENABLE_OUT       <= RD_WRITE_ENABLE_IN && !misaligned;
                        MISALIGNED_OUT            <= misaligned;
                    end else begin
                        MISALIGNED_OUT <= 1'b0;
                        state          <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dcache.DCACHE_REQ_READY) begin
                        state <= is_load ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (dcache.DCACHE_RESP_VALID) begin
                        hold_data <= load_ext;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    RD_ADDRESS_OUT            <= RD_ADDRESS_IN;
                    ALU_OUT                   <= ALU_OUT_IN;
                    MEM_DATA_OUT              <= is_load ? hold_data : '0;
                    WRITE_BACK_MUX_SELECT_OUT <= WRITE_BACK_MUX_SELECT_IN;
                    RD_WRITE_ENABLE_OUT       <= RD_WRITE_ENABLE_IN;
                    MISALIGNED_OUT            <= 1'b0;
                    state                     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed vector table, reset-in-WAIT sequence and random ops
// checked against a byte-level reference model with an expected-output queue.
module tb_memory_access_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  rd_in;
    logic [31:0] alu_in;
    logic [2:0]  ld_in;
    logic [1:0]  st_in;
    logic [31:0] sdata_in;
    logic        wbsel_in;
    logic        we_in;
    logic        stall;
    logic [4:0]  rd_out;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic        wbsel_out;
    logic        we_out;
    logic        mis_out;
    logic [1:0]  state_out;

    memory_access_stage_if mif ();

    memory_access_stage dut (
        .CLK(CLK), .RST(RST),
        .RD_ADDRESS_IN(rd_in), .ALU_OUT_IN(alu_in),
        .DATA_CACHE_LOAD_IN(ld_in), .DATA_CACHE_STORE_IN(st_in),
        .DATA_CACHE_STORE_DATA(sdata_in),
        .WRITE_BACK_MUX_SELECT_IN(wbsel_in), .RD_WRITE_ENABLE_IN(we_in),
        .STALL_EXECUTION_STAGE(stall), .dcache(mif.master),
        .RD_ADDRESS_OUT(rd_out), .ALU_OUT(alu_out), .MEM_DATA_OUT(mem_out),
        .WRITE_BACK_MUX_SELECT_OUT(wbsel_out), .RD_WRITE_ENABLE_OUT(we_out),
        .MISALIGNED_OUT(mis_out), .STATE_OUT(state_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wbsel;
        logic        we;
    } op_t;

    typedef struct {
        logic        is_load;
        logic        is_store;
        logic        mis;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        we;
        int          stalls;
        int          vcyc;
    } ref_t;

    typedef struct {
        string       name;
        op_t         op;
        int          rdy;
        int          rsp;
        logic [31:0] exp_mem;
        logic        exp_mis;
        logic        exp_we;
        int          exp_stalls;
        int          exp_vcyc;
        bit          chk_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    logic [71:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: access size in bytes, offset within the word, lanes touched by the access.
    function automatic ref_t ref_model(input op_t o, input int rdy, input int rsp);
        ref_t r;
        int size;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        r.is_load  = (o.ld >= 3'd1) && (o.ld <= 3'd5);
        r.is_store = !r.is_load && (o.st != 2'd0);
        size = 0;
        if (r.is_load) size = (o.ld == 3'd1 || o.ld == 3'd4) ? 1 : (o.ld == 3'd3) ? 4 : 2;
        else if (r.is_store) size = (o.st == 2'd1) ? 1 : (o.st == 2'd2) ? 2 : 4;
        off   = int'(o.alu[1:0]);
        r.mis = (size != 0) && ((off % size) != 0);
        r.addr = o.alu - 32'(off);
        r.be = 4'b0000;
        r.wdata = 32'd0;
        if (r.is_store) begin
            for (int i = 0; i < 4; i++) begin
                r.be[i] = (i >= off) && (i < off + size);
                r.wdata[8*i +: 8] = o.sdata[8*(i % size) +: 8];
            end
        end
        r.mem = 32'd0;
        if (r.is_load && !r.mis) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v = (o.rdata >> (8 * off)) & mask;
            if ((o.ld == 3'd1 || o.ld == 3'd2) && v[8*size-1]) v = v | ~mask;
            r.mem = v;
        end
        r.we = r.mis ? 1'b0 : o.we;
        if (!(r.is_load || r.is_store) || r.mis) begin
            r.stalls = 0;
            r.vcyc   = 0;
        end else begin
            r.stalls = r.is_load ? 3 + rdy + rsp : 2 + rdy;
            r.vcyc   = rdy + 1;
        end
        return r;
    endfunction

    // Drives one op from a negedge and plays the cache: READY after rdy extra VALID cycles,
    // RESP_VALID rsp cycles after a load is accepted. Returns on the negedge after capture.
    task automatic do_op(input op_t o, input int rdy, input int rsp, input bit noise,
                         output int stalls, output int vcyc,
                         output logic [3:0] last_be, output logic [31:0] last_wd);
        ref_t r;
        int cyc;
        int waitc;
        bit done;
        bit accepted;
        bit resp_sent;
        bit acc_now;
        r = ref_model(o, rdy, rsp);
        exp_q.push_back({o.rd, o.alu, r.mem, o.wbsel, r.we, r.mis});
        rd_in = o.rd; alu_in = o.alu; ld_in = o.ld; st_in = o.st;
        sdata_in = o.sdata; wbsel_in = o.wbsel; we_in = o.we;
        stalls = 0; vcyc = 0; last_be = 4'b0000; last_wd = 32'd0;
        cyc = 0; waitc = 0; done = 0; accepted = 0; resp_sent = 0;
        while (!done && cyc < 64) begin
            #1;
            if (stall) stalls++;
            acc_now = 0;
            if (mif.DCACHE_REQ_VALID) begin
                vcyc++;
                chk("req_addr", 72'(mif.DCACHE_REQ_ADDRESS), 72'(r.addr));
                chk("req_write", 72'(mif.DCACHE_REQ_WRITE), 72'(r.is_store));
                chk("req_byte_en", 72'(mif.DCACHE_REQ_BYTE_EN), 72'(r.be));
                if (r.is_store) chk("req_wdata", 72'(mif.DCACHE_REQ_WDATA), 72'(r.wdata));
                last_be = mif.DCACHE_REQ_BYTE_EN;
                last_wd = mif.DCACHE_REQ_WDATA;
                mif.DCACHE_REQ_READY = (vcyc > rdy);
                acc_now = (vcyc > rdy);
            end else begin
                mif.DCACHE_REQ_READY = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (accepted && !resp_sent) begin
                if (waitc == rsp) begin
                    mif.DCACHE_RESP_VALID = 1'b1;
                    mif.DCACHE_RESP_DATA  = o.rdata;
                    resp_sent = 1;
                end else begin
                    mif.DCACHE_RESP_VALID = 1'b0;
                    mif.DCACHE_RESP_DATA  = $urandom;
                end
                waitc++;
            end else begin
                mif.DCACHE_RESP_VALID = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mif.DCACHE_RESP_DATA  = $urandom;
            end
            if (!stall) done = 1;
            @(posedge CLK);
            if (acc_now && r.is_load) accepted = 1;
            @(negedge CLK);
            cyc++;
        end
        mif.DCACHE_REQ_READY  = 1'b0;
        mif.DCACHE_RESP_VALID = 1'b0;
        if (!done) chk("op_timeout", 72'd0, 72'd1);
        chk("wb_outputs", {rd_out, alu_out, mem_out, wbsel_out, we_out, mis_out}, exp_q.pop_front());
        chk("stall_cycles", 72'(stalls), 72'(r.stalls));
        chk("req_cycles", 72'(vcyc), 72'(r.vcyc));
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_outputs"}, {rd_out, alu_out, mem_out, wbsel_out, we_out, mis_out}, 72'd0);
        chk({name, "_state"}, 72'(state_out), 72'd0);
        chk({name, "_valid"}, 72'(mif.DCACHE_REQ_VALID), 72'd0);
        chk({name, "_stall"}, 72'(stall), 72'd0);
    endtask

    task automatic zero_inputs();
        rd_in = '0; alu_in = '0; ld_in = '0; st_in = '0;
        sdata_in = '0; wbsel_in = 1'b0; we_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        op_t  o;
        int   stalls;
        int   vcyc;
        logic [3:0]  lbe;
        logic [31:0] lwd;

        tbl[0]  = '{"nop",      '{3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1}, 0, 0, 32'h0, 1'b0, 1'b1, 0, 0, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{"lb",       '{3'd1, 2'd0, 32'h103, 32'h0, 32'h80FF_FF00, 5'd6, 1'b1, 1'b1}, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b1, 3, 1, 1'b0, 4'h0, 32'h0};
        tbl[2]  = '{"lhu",      '{3'd5, 2'd0, 32'h102, 32'h0, 32'h8001_0000, 5'd7, 1'b1, 1'b1}, 0, 0, 32'h0000_8001, 1'b0, 1'b1, 3, 1, 1'b0, 4'h0, 32'h0};
        tbl[3]  = '{"lh",       '{3'd2, 2'd0, 32'h102, 32'h0, 32'h8001_0000, 5'd8, 1'b1, 1'b1}, 0, 0, 32'hFFFF_8001, 1'b0, 1'b1, 3, 1, 1'b0, 4'h0, 32'h0};
        tbl[4]  = '{"sh_wait",  '{3'd0, 2'd2, 32'h206, 32'h0000_BEEF, 32'h0, 5'd9, 1'b0, 1'b0}, 2, 0, 32'h0, 1'b0, 1'b0, 4, 3, 1'b1, 4'b1100, 32'hBEEF_BEEF};
        tbl[5]  = '{"sw_mis",   '{3'd0, 2'd3, 32'h301, 32'hAAAA_5555, 32'h0, 5'd10, 1'b0, 1'b1}, 0, 0, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 4'h0, 32'h0};
        tbl[6]  = '{"lw_slow",  '{3'd3, 2'd0, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd11, 1'b1, 1'b1}, 1, 2, 32'hDEAD_BEEF, 1'b0, 1'b1, 6, 2, 1'b0, 4'h0, 32'h0};
        tbl[7]  = '{"sb",       '{3'd0, 2'd1, 32'h101, 32'h1234_5678, 32'h0, 5'd12, 1'b0, 1'b0}, 0, 0, 32'h0, 1'b0, 1'b0, 2, 1, 1'b1, 4'b0010, 32'h7878_7878};
        tbl[8]  = '{"lbu",      '{3'd4, 2'd0, 32'h102, 32'h0, 32'h11AA_2233, 5'd13, 1'b1, 1'b1}, 0, 0, 32'h0000_00AA, 1'b0, 1'b1, 3, 1, 1'b0, 4'h0, 32'h0};
        tbl[9]  = '{"ld_wins",  '{3'd3, 2'd3, 32'h10, 32'h9999_9999, 32'hCAFE_F00D, 5'd14, 1'b1, 1'b1}, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 4, 1, 1'b1, 4'b0000, 32'h0};
        tbl[10] = '{"ld_code6", '{3'd6, 2'd0, 32'h55, 32'h0, 32'h0, 5'd15, 1'b0, 1'b1}, 0, 0, 32'h0, 1'b0, 1'b1, 0, 0, 1'b0, 4'h0, 32'h0};
        tbl[11] = '{"lh_mis",   '{3'd2, 2'd0, 32'h101, 32'h0, 32'h0, 5'd16, 1'b1, 1'b1}, 0, 0, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 4'h0, 32'h0};
        tbl[12] = '{"sw",       '{3'd0, 2'd3, 32'h300, 32'hCAFE_BABE, 32'h0, 5'd17, 1'b0, 1'b0}, 3, 0, 32'h0, 1'b0, 1'b0, 5, 4, 1'b1, 4'hF, 32'hCAFE_BABE};
        tbl[13] = '{"lb_slow",  '{3'd1, 2'd0, 32'h200, 32'h0, 32'h0000_007F, 5'd18, 1'b1, 1'b1}, 0, 3, 32'h0000_007F, 1'b0, 1'b1, 6, 1, 1'b0, 4'h0, 32'h0};

        // Clock/reset
        RST = 1'b1;
        zero_inputs();
        mif.DCACHE_REQ_READY  = 1'b0;
        mif.DCACHE_RESP_VALID = 1'b0;
        mif.DCACHE_RESP_DATA  = '0;
        repeat (2) @(negedge CLK);
        #1;
        check_cleared("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].rdy, tbl[i].rsp, 1'b0, stalls, vcyc, lbe, lwd);
            chk({tbl[i].name, "_mem"}, 72'(mem_out), 72'(tbl[i].exp_mem));
            chk({tbl[i].name, "_mis"}, 72'(mis_out), 72'(tbl[i].exp_mis));
            chk({tbl[i].name, "_we"}, 72'(we_out), 72'(tbl[i].exp_we));
            chk({tbl[i].name, "_stalls"}, 72'(stalls), 72'(tbl[i].exp_stalls));
            chk({tbl[i].name, "_vcyc"}, 72'(vcyc), 72'(tbl[i].exp_vcyc));
            if (tbl[i].chk_req) begin
                chk({tbl[i].name, "_be"}, 72'(lbe), 72'(tbl[i].exp_be));
                if (tbl[i].exp_be != 4'h0) chk({tbl[i].name, "_wdata"}, 72'(lwd), 72'(tbl[i].exp_wdata));
            end
        end

        // Reset while waiting for a load response; the late response must be dropped.
        ld_in = 3'd3; st_in = 2'd0; alu_in = 32'h40; rd_in = 5'd3;
        we_in = 1'b1; wbsel_in = 1'b1; sdata_in = '0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        mif.DCACHE_REQ_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        mif.DCACHE_REQ_READY = 1'b0;
        #1;
        chk("wait_stall", 72'(stall), 72'd1);
        RST = 1'b1;
        zero_inputs();
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check_cleared("rst_in_wait");
        RST = 1'b0;
        mif.DCACHE_RESP_VALID = 1'b1;
        mif.DCACHE_RESP_DATA  = 32'hFFFF_FFFF;
        @(posedge CLK);
        @(negedge CLK);
        mif.DCACHE_RESP_VALID = 1'b0;
        #1;
        check_cleared("late_resp");
        o = '{3'd3, 2'd0, 32'h40, 32'h0, 32'h0BAD_F00D, 5'd3, 1'b1, 1'b1};
        do_op(o, 0, 0, 1'b0, stalls, vcyc, lbe, lwd);
        chk("post_reset_lw", 72'(mem_out), 72'h0BAD_F00D);

        // Random ops with READY/RESP noise outside the phases where they matter
        for (int n = 0; n < 300; n++) begin
            o.ld    = 3'($urandom_range(0, 7));
            o.st    = 2'($urandom_range(0, 3));
            o.alu   = $urandom;
            o.sdata = $urandom;
            o.rdata = $urandom;
            o.rd    = 5'($urandom_range(0, 31));
            o.wbsel = 1'($urandom_range(0, 1));
            o.we    = 1'($urandom_range(0, 1));
            do_op(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, stalls, vcyc, lbe, lwd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
